cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter IMG_W, default 640: pixels per stored line.
REQ-002 Parameter IMG_H, default 294: lines per stored frame.
REQ-003 Parameter ADDR_W, default 18: frame-buffer address width.
REQ-004 Port PixelClk, input, 1: the single clock; all inputs are sampled and all outputs are driven on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port pixdata, input, 8: camera data byte.
REQ-007 Port hsync, input, 1: camera line-valid (HREF), active-high.
REQ-008 Port vsync, input, 1: camera frame sync, active-high during vertical blanking.
REQ-009 Port capture_en, input, 1: level; high arms capture of successive frames.
REQ-010 Port wr_en, output, 1: frame-buffer write strobe.
REQ-011 Port wr_addr, output, ADDR_W: frame-buffer write address.
REQ-012 Port wr_data, output, 4: pixel value, equal to pixdata[7:4].
REQ-013 Port frame_done, output, 1: one-cycle pulse when a frame ends.
REQ-014 Port busy, output, 1: high in the CAPTURE state.
REQ-015 Port overflow, output, 1: sticky flag; set when pixels or lines exceed IMG_W/IMG_H.

Function
REQ-016 pixdata, hsync and vsync SHALL each pass through exactly one input register stage.
REQ-017 The FSM SHALL have four states: IDLE, WAIT_VS, CAPTURE, DONE.
REQ-018 IDLE SHALL go to WAIT_VS when capture_en=1.
REQ-019 WAIT_VS SHALL go to CAPTURE on a registered-vsync falling edge; a partial frame is never captured.
REQ-020 CAPTURE SHALL go to DONE on a registered-vsync rising edge.
REQ-021 CAPTURE SHALL go to DONE on the falling edge of registered hsync that completes line IMG_H-1.
REQ-022 DONE SHALL last one cycle, assert frame_done, then go to WAIT_VS if capture_en=1, else IDLE.
REQ-023 If capture_en drops during CAPTURE, the current frame SHALL complete; capture_en is then re-evaluated in DONE.
REQ-024 Counters SHALL be col (pixel in line) and row (line in frame); both clear on entry to CAPTURE; col also clears on each registered-hsync rising edge.
REQ-025 row SHALL increment on each registered-hsync falling edge in CAPTURE.
REQ-026 Each accepted pixel SHALL write at wr_addr = row*IMG_W + col, computed at ADDR_W width without truncation (IMG_W*IMG_H <= 2^ADDR_W).
REQ-027 A short line SHALL leave its tail unwritten; the next line still starts at a row*IMG_W boundary.
REQ-028 Pixels with col >= IMG_W or row >= IMG_H SHALL NOT be written and SHALL set overflow.
REQ-029 Latency: wr_en/wr_addr/wr_data SHALL be valid exactly 2 PixelClk cycles after the byte is present on pixdata.
REQ-030 wr_en SHALL be a single cycle per accepted pixel.
REQ-031 A vsync rising edge mid-line SHALL end the frame immediately; no further writes occur.

Reset
REQ-032 While reset=1: state=IDLE; col, row, input registers and byte phase =0; wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, overflow=0.
REQ-033 Reset asserted mid-frame SHALL abort with no further writes; after release the block waits for a fresh vsync falling edge.
REQ-034 overflow SHALL clear only on reset.

Configuration
REQ-035 With CAM_CAPTURE_YUV_EN defined: input is YUV422; only even-phase bytes (Y) of each line are accepted; the phase toggles per byte and clears on each registered-hsync rising edge.
REQ-036 Without CAM_CAPTURE_YUV_EN: every byte with registered hsync=1 is one pixel.

Structure
REQ-037 Package cam_pkg SHALL hold the IMG_W/IMG_H/ADDR_W defaults and the FSM state enum; the display stage shares the dimension constants.
REQ-038 A single sub-module, cam_edge_det, SHALL provide rise/fall pulses for registered hsync and vsync.

Verification
REQ-039 Raw mode, capture_en=1, frame of 294 lines x 640 bytes -> 188160 writes, addresses 0..188159, one frame_done pulse, overflow=0.
REQ-040 Line 3 carries 600 bytes -> last write of the line at 3*640+599=2519; next line's first write at 2560.
REQ-041 Line of 700 bytes -> 640 writes, overflow=1; overflow stays 1 across the next frame.
REQ-042 capture_en raised mid-frame -> no writes until after the next vsync falling edge.
REQ-043 CAM_CAPTURE_YUV_EN, line of 1280 bytes -> 640 writes; wr_data = upper nibble of bytes 0,2,4,...
REQ-044 Reset pulsed at row 100 -> wr_en=0 the next cycle; the following frame starts at wr_addr=0.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared constants and FSM state type for the camera capture path.
// The display stage imports the same dimension constants.
package cam_pkg;

    localparam int unsigned CAM_IMG_W  = 640;
    localparam int unsigned CAM_IMG_H  = 294;
    localparam int unsigned CAM_ADDR_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_CAPTURE,
        ST_DONE
    } cam_state_t;

endpackage

// File: rtl/cam_capture_edge_det.sv
// Rise/fall pulse generator for already-registered sync signals.
// Pulses are combinational off the input and a one-cycle delayed copy.
module cam_edge_det #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sig,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_prev;

    // Remember last cycle's level of each signal.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= '0;
        else       r_prev <= i_sig;
    end

    // Edge pulses are high for the first cycle at the new level.
    always_comb begin
        o_rise = i_sig & ~r_prev;
        o_fall = ~i_sig & r_prev;
    end

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture into a linear frame buffer (row*IMG_W + col).
// Optional feature: define CAM_CAPTURE_YUV_EN to accept YUV422 input,
// keeping only the even-phase (Y) byte of each pair on a line.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W  = CAM_IMG_W,
    parameter int unsigned IMG_H  = CAM_IMG_H,
    parameter int unsigned ADDR_W = CAM_ADDR_W
) (
    input  logic              PixelClk,
    input  logic              reset,
    input  logic [7:0]        pixdata,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned COL_W = $clog2(IMG_W + 1);
    localparam int unsigned ROW_W = $clog2(IMG_H + 1);

    logic [7:0]       r_pix;
    logic             r_hs;
    logic             r_vs;
    logic [1:0]       w_rise;
    logic [1:0]       w_fall;
    logic             w_hs_rise;
    logic             w_hs_fall;
    logic             w_vs_rise;
    logic             w_vs_fall;
    cam_state_t       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col;
    logic             w_accept;
    logic             w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic             w_unused_lo;

    // Single input register stage for camera data and syncs.
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            r_pix <= '0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
        end else begin
            r_pix <= pixdata;
            r_hs  <= hsync;
            r_vs  <= vsync;
        end
    end

    // Only the upper nibble is stored; the low nibble is deliberately dropped.
    assign w_unused_lo = ^r_pix[3:0];

    cam_edge_det #(
        .WIDTH (2)
    ) u_edge (
        .i_clk  (PixelClk),
        .i_rst  (reset),
        .i_sig  ({r_vs, r_hs}),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_hs_rise = w_rise[0];
    assign w_hs_fall = w_fall[0];
    assign w_vs_rise = w_rise[1];
    assign w_vs_fall = w_fall[1];

`ifdef CAM_CAPTURE_YUV_EN
    logic r_phase;

    // Byte phase within a line: the first byte of a line is phase 0 (Y),
    // so on the hsync rise the next byte is already phase 1.
    always_ff @(posedge PixelClk) begin
        if (reset)          r_phase <= 1'b0;
        else if (w_hs_rise) r_phase <= 1'b1;
        else if (r_hs)      r_phase <= ~r_phase;
    end

    // Accept only Y bytes; the rise cycle is phase 0 regardless of r_phase.
    always_comb begin
        w_accept = r_hs & (w_hs_rise | ~r_phase);
    end
`else
    // Every byte with line-valid high is one pixel.
    always_comb begin
        w_accept = r_hs;
    end
`endif

    // Column seen by the current byte (a new line starts at 0) and its address.
    always_comb begin
        w_col      = w_hs_rise ? '0 : r_col;
        w_in_range = (w_col < COL_W'(IMG_W)) && (r_row < ROW_W'(IMG_H));
        w_addr     = ADDR_W'(r_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col);
    end

    // Capture FSM with counters and registered write/status outputs.
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (capture_en) r_state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_state <= ST_CAPTURE;
                        busy    <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_state    <= ST_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (w_hs_fall) begin
                        r_row <= r_row + ROW_W'(1);
                        if (r_row == ROW_W'(IMG_H - 1)) begin
                            r_state    <= ST_DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end else begin
                        if (w_hs_rise) r_col <= '0;
                        if (w_accept) begin
                            if (w_in_range) begin
                                wr_en   <= 1'b1;
                                wr_addr <= w_addr;
                                wr_data <= r_pix[7:4];
                            end else begin
                                overflow <= 1'b1;
                            end
                            // Column saturates at IMG_W so long lines cannot wrap.
                            if (w_col != COL_W'(IMG_W)) r_col <= w_col + COL_W'(1);
                            else                        r_col <= w_col;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= capture_en ? ST_WAIT_VS : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture with reduced frame dimensions.
module tb_cam_capture;

    localparam int unsigned IMG_W  = 16;
    localparam int unsigned IMG_H  = 6;
    localparam int unsigned ADDR_W = 7;
`ifdef CAM_CAPTURE_YUV_EN
    localparam int BPP = 2;
`else
    localparam int BPP = 1;
`endif

    logic              PixelClk = 1'b0;
    logic              reset;
    logic [7:0]        pixdata;
    logic              hsync;
    logic              vsync;
    logic              capture_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              frame_done;
    logic              busy;
    logic              overflow;

    cam_capture #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .PixelClk   (PixelClk),
        .reset      (reset),
        .pixdata    (pixdata),
        .hsync      (hsync),
        .vsync      (vsync),
        .capture_en (capture_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 PixelClk = ~PixelClk;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        data;
        logic              done;
        logic              busy;
        logic              ovf;
    } exp_t;

    // Directed frame description; lengths are in pixels.
    typedef struct {
        int nlines;
        int len;
        int sp_line;
        int sp_len;
        int cut_line;
        int cut_pix;
        int exp_wr;
        int exp_last;
        int exp_done;
        int exp_ovf;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wr;
    int   n_done;
    int   first_addr;
    int   last_addr;
    exp_t prev_exp = '0;

    // Reference model state: frame/line/byte positions as the camera produced them.
    bit m_cap      = 1'b0;
    int m_line     = 0;
    int m_byte     = 0;
    bit m_prev_hs  = 1'b0;
    bit m_prev_vs  = 1'b0;
    bit m_ovf      = 1'b0;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", what, act, req, $time);
        end
    endtask

    // Expected outputs two cycles after this drive, from frame geometry rules.
    task automatic model_step(input logic [7:0] pix, input logic hs, input logic vs,
                              input logic rst, input logic cen, output exp_t e);
        int p;
        e = '0;
        if (rst) begin
            m_cap = 1'b0; m_ovf = 1'b0; m_line = 0; m_byte = 0;
            m_prev_hs = 1'b0; m_prev_vs = 1'b0;
        end else begin
            if (m_cap && vs && !m_prev_vs) begin
                m_cap  = 1'b0;
                e.done = 1'b1;
            end else if (m_cap && !hs && m_prev_hs) begin
                m_line++;
                if (m_line == IMG_H) begin
                    m_cap  = 1'b0;
                    e.done = 1'b1;
                end
            end else if (m_cap && hs) begin
                m_byte = m_prev_hs ? m_byte + 1 : 0;
                if (m_byte % BPP == 0) begin
                    p = m_byte / BPP;
                    if (p < IMG_W && m_line < IMG_H) begin
                        e.wr   = 1'b1;
                        e.addr = ADDR_W'(m_line * IMG_W + p);
                        e.data = pix[7:4];
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (!m_cap && !vs && m_prev_vs && cen) begin
                m_cap  = 1'b1;
                m_line = 0;
            end
            m_prev_hs = hs;
            m_prev_vs = vs;
            e.busy = m_cap;
            e.ovf  = m_ovf;
        end
    endtask

    // One clock: drive inputs, advance, then compare the slot due now.
    task automatic step(input logic [7:0] pix, input logic hs, input logic vs);
        exp_t e;
        pixdata = pix; hsync = hs; vsync = vs;
        model_step(pix, hs, vs, reset, capture_en, e);
        @(posedge PixelClk);
        @(negedge PixelClk);
        if (reset) prev_exp = '0;
        check("wr_en", wr_en, prev_exp.wr);
        if (prev_exp.wr) begin
            check("wr_addr", wr_addr, prev_exp.addr);
            check("wr_data", wr_data, prev_exp.data);
        end
        check("frame_done", frame_done, prev_exp.done);
        check("busy", busy, prev_exp.busy);
        check("overflow", overflow, prev_exp.ovf);
        if (wr_en === 1'b1) begin
            if (n_wr == 0) first_addr = int'(wr_addr);
            n_wr++;
            last_addr = int'(wr_addr);
        end
        if (frame_done === 1'b1) n_done++;
        prev_exp = e;
    endtask

    task automatic send_line(input int nbytes, input int cut, output bit was_cut);
        was_cut = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            if (b == cut) begin
                step(8'($urandom), 1'b1, 1'b1);
                was_cut = 1'b1;
                break;
            end
            step(8'($urandom), 1'b1, 1'b0);
        end
        if (!was_cut) step(8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int len, input int sp_line, input int sp_len,
                              input int cut_line, input int cut_pix, input int cen_l1);
        bit cut;
        int l_len;
        int l_cut;
        step(8'h00, 1'b0, 1'b0);
        step(8'($urandom), 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            if (l == 1 && cen_l1 >= 0) capture_en = (cen_l1 != 0);
            l_len = (l == sp_line) ? sp_len : len;
            l_cut = (l == cut_line) ? cut_pix * BPP : -1;
            send_line(l_len * BPP, l_cut, cut);
            if (cut) break;
            step(8'($urandom), 1'b0, 1'b0);
        end
        repeat (4) step(8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic rand_frame();
        int  nl;
        int  cl;
        int  nb;
        int  ci;
        bit  cut;
        nl = $urandom_range(IMG_H + 2, 2);
        cl = ($urandom_range(7, 0) == 0) ? int'($urandom_range(nl - 1, 0)) : -1;
        repeat ($urandom_range(3, 1)) step(8'($urandom), 1'b0, 1'b0);
        for (int l = 0; l < nl; l++) begin
            if (l == 1 && $urandom_range(3, 0) == 0) capture_en = ~capture_en;
            nb = ($urandom_range(1, 0) == 0) ? IMG_W * BPP : int'($urandom_range((IMG_W + 3) * BPP, 1));
            ci = (l == cl) ? int'($urandom_range(nb - 1, 0)) : -1;
            send_line(nb, ci, cut);
            if (cut) break;
            repeat ($urandom_range(2, 0)) step(8'($urandom), 1'b0, 1'b0);
        end
        repeat ($urandom_range(5, 3)) step(8'($urandom), 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{6, 16, -1,  0, -1, 0, 96, 95, 1, 0};  // full frame
        tbl[1] = '{6, 16,  3, 12, -1, 0, 92, 95, 1, 0};  // short line 3
        tbl[2] = '{8, 16, -1,  0, -1, 0, 96, 95, 1, 0};  // extra lines ignored
        tbl[3] = '{4, 16, -1,  0,  2, 5, 37, 36, 1, 0};  // vsync mid-line
        tbl[4] = '{3, 10, -1,  0, -1, 0, 30, 41, 1, 0};  // short frame
        tbl[5] = '{6, 16,  2, 20, -1, 0, 96, 95, 1, 1};  // long line overflows
        tbl[6] = '{6, 16, -1,  0, -1, 0, 96, 95, 1, 1};  // overflow stays set

        reset = 1'b1; capture_en = 1'b0; pixdata = '0; hsync = 1'b0; vsync = 1'b1;
        n_wr = 0; n_done = 0; first_addr = 0; last_addr = 0;
        repeat (3) step(8'hff, 1'b0, 1'b1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);

        reset = 1'b0;
        capture_en = 1'b1;
        repeat (4) step(8'($urandom), 1'b0, 1'b1);

        for (int i = 0; i < 7; i++) begin
            n_wr = 0; n_done = 0;
            send_frame(tbl[i].nlines, tbl[i].len, tbl[i].sp_line, tbl[i].sp_len,
                       tbl[i].cut_line, tbl[i].cut_pix, -1);
            check($sformatf("tbl%0d_writes", i), n_wr, tbl[i].exp_wr);
            check($sformatf("tbl%0d_last_addr", i), last_addr, tbl[i].exp_last);
            check($sformatf("tbl%0d_done", i), n_done, tbl[i].exp_done);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].exp_ovf);
        end

        // Drop capture_en mid-frame: frame completes, next frame is skipped.
        n_wr = 0; n_done = 0;
        send_frame(6, 16, -1, 0, -1, 0, 0);
        check("cen_drop_writes", n_wr, 96);
        check("cen_drop_done", n_done, 1);
        n_wr = 0; n_done = 0;
        send_frame(6, 16, -1, 0, -1, 0, 1);
        check("cen_raise_writes", n_wr, 0);
        check("cen_raise_done", n_done, 0);
        n_wr = 0; n_done = 0;
        send_frame(6, 16, -1, 0, -1, 0, -1);
        check("cen_next_writes", n_wr, 96);
        check("cen_next_first", first_addr, 0);

        // Reset in the middle of line 3.
        begin
            bit cut;
            step(8'h00, 1'b0, 1'b0);
            step(8'($urandom), 1'b0, 1'b0);
            for (int l = 0; l < 3; l++) begin
                send_line(IMG_W * BPP, -1, cut);
                step(8'($urandom), 1'b0, 1'b0);
            end
            for (int b = 0; b < 5 * BPP; b++) step(8'($urandom), 1'b1, 1'b0);
            reset = 1'b1;
            step(8'($urandom), 1'b1, 1'b0);
            check("rst_mid_wr_en", wr_en, 0);
            check("rst_mid_overflow", overflow, 0);
            reset = 1'b0;
            n_wr = 0;
            for (int b = 5 * BPP + 1; b < IMG_W * BPP; b++) step(8'($urandom), 1'b1, 1'b0);
            step(8'($urandom), 1'b0, 1'b0);
            for (int l = 4; l < 6; l++) begin
                send_line(IMG_W * BPP, -1, cut);
                step(8'($urandom), 1'b0, 1'b0);
            end
            repeat (4) step(8'($urandom), 1'b0, 1'b1);
            check("rst_mid_no_writes", n_wr, 0);
        end
        n_wr = 0; n_done = 0;
        send_frame(6, 16, -1, 0, -1, 0, -1);
        check("post_rst_first", first_addr, 0);
        check("post_rst_writes", n_wr, 96);
        check("post_rst_overflow", overflow, 0);

        for (int f = 0; f < 40; f++) rand_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
